// File: rtl/load_store_unit.sv
// Load/store memory stage: turns an ALU effective address into a word-addressed
// memory request/ready handshake and returns extended load data with a done pulse.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [31:0] LP_TO_LAST = 32'(TIMEOUT - 1);
  localparam bit          LP_TO_EN   = (TIMEOUT != 0);

  state_t      r_state;
  state_t      w_next;
  logic        r_is_store;
  logic [2:0]  r_func3;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [31:0] r_cnt;
  logic [1:0]  r_err_code;
  logic [31:0] r_load_data;

  logic        w_illegal;
  logic        w_misalign;
  logic        w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;

  // Request checks are made on the live inputs so errors skip REQ entirely.
  assign w_illegal  = is_store ? (func3[2] | (func3[1:0] == 2'b11))
                               : ((func3 == 3'b011) | (func3[2:1] == 2'b11));
  assign w_misalign = ((func3[1:0] == 2'b01) & addr[0]) |
                      ((func3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign w_timeout  = LP_TO_EN && (r_cnt == LP_TO_LAST) && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = (w_illegal || w_misalign) ? S_DONE : S_REQ;
      S_REQ:  if (mem_ready || w_timeout) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_func3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    case (r_func3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_sdata[7:0]}};
      end
      2'b01: begin
        w_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_sdata[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = r_sdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_store  <= 1'b0;
      r_func3     <= 3'd0;
      r_addr      <= 32'd0;
      r_sdata     <= 32'd0;
      r_cnt       <= 32'd0;
      r_err_code  <= 2'b00;
      r_load_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 32'd0;
          if (start) begin
            r_is_store <= is_store;
            r_func3    <= func3;
            r_addr     <= addr;
            r_sdata    <= store_data;
            r_err_code <= w_illegal ? 2'b11 : (w_misalign ? 2'b01 : 2'b00);
          end
        end
        S_REQ: begin
          // A response arriving on the timeout edge still completes the access.
          if (mem_ready) begin
            r_err_code <= 2'b00;
            if (!r_is_store) r_load_data <= w_load_ext;
          end else begin
            r_cnt <= r_cnt + 32'd1;
            if (w_timeout) r_err_code <= 2'b10;
          end
        end
        default: r_cnt <= 32'd0;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = done && (r_err_code != 2'b00);
  assign err_code  = done ? r_err_code : 2'b00;
  assign load_data = r_load_data;
  assign mem_req   = (r_state == S_REQ);
  assign mem_we    = mem_req & r_is_store;
  assign mem_addr  = mem_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_wdata = mem_we ? w_wdata : 32'd0;
  assign mem_wstrb = mem_we ? w_wstrb : 4'b0000;

endmodule
